fetch_pc_ctrl: RTL and testbench

Fetch-side program-counter controller for the 5-stage pipeline: owns the PC register and consumes the branch-resolution result (`PcSel`, `BrPC`, `Halt`) produced in EX. It advances the PC by 4, applies stalls from the hazard unit, and redirects on taken branches, jumps and halts. On each redirect it generates the IF/ID and ID/EX squash pulse. A small FSM parks the core on halt or on a misaligned redirect target.

---
 rtl/fetch_pc_ctrl_if.sv | 36 +++
 rtl/fetch_pc_ctrl.sv | 106 ++++++++++
 tb/tb_fetch_pc_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch PC controller bus: EX/hazard-side requests in, fetch address and status out.
// Optional perf counter signals exist only when FETCH_PC_PERF_CNT_EN is defined.
interface fetch_pc_ctrl_if #(
    parameter int PC_W = 9
);
    logic            Stall;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Halt;
    logic            Resume;
    logic [PC_W-1:0] PC;
    logic            PC_Valid;
    logic            Flush;
    logic            Halted;
    logic            Misalign;
`ifdef FETCH_PC_PERF_CNT_EN
    logic [15:0]     RedirectCnt;
    logic [15:0]     StallCnt;
`endif

    modport master (
        output Stall, PcSel, BrPC, Halt, Resume,
`ifdef FETCH_PC_PERF_CNT_EN
        input  RedirectCnt, StallCnt,
`endif
        input  PC, PC_Valid, Flush, Halted, Misalign
    );

    modport slave (
        input  Stall, PcSel, BrPC, Halt, Resume,
`ifdef FETCH_PC_PERF_CNT_EN
        output RedirectCnt, StallCnt,
`endif
        output PC, PC_Valid, Flush, Halted, Misalign
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC register with stall, EX redirect/squash and a RUN/HALTED park FSM.
// Define FETCH_PC_PERF_CNT_EN to add saturating redirect and stall counters.
module fetch_pc_ctrl #(
    parameter int PC_W = 9
) (
    input  logic               clk,
    input  logic               reset,
    fetch_pc_ctrl_if.slave     bus
);
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            misalign_reg, misalign_next;
    logic            flush_run;
    logic [PC_W-1:0] br_target;
    logic            br_misaligned;

    // Redirect targets are forced to word alignment; upper BrPC bits are dropped.
    assign br_target     = {bus.BrPC[PC_W-1:2], 2'b00};
    assign br_misaligned = (bus.BrPC[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= RUN;
            pc_reg       <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        misalign_next = misalign_reg;
        flush_run     = 1'b0;
        case (state_reg)
            RUN: begin
                if (bus.PcSel) begin
                    flush_run = 1'b1;
                    pc_next   = br_target;
                    if (bus.Halt || br_misaligned) begin
                        state_next = HALTED;
                    end
                    if (br_misaligned) begin
                        misalign_next = 1'b1;
                    end
                end else if (!bus.Stall) begin
                    pc_next = pc_reg + PC_W'(4);
                end
            end
            HALTED: begin
                // Resume skips past the parked (halt) instruction.
                if (bus.Resume) begin
                    pc_next    = pc_reg + PC_W'(4);
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign bus.PC       = pc_reg;
    assign bus.Halted   = (state_reg == HALTED);
    assign bus.Misalign = misalign_reg;
    assign bus.PC_Valid = reset && (state_reg == RUN);
    assign bus.Flush    = reset && flush_run;

`ifdef FETCH_PC_PERF_CNT_EN
    logic [15:0] redirect_cnt_reg, redirect_cnt_next;
    logic [15:0] stall_cnt_reg, stall_cnt_next;

    // flush_run is only ever high in RUN, so HALTED freezes both counters.
    always_comb begin
        redirect_cnt_next = redirect_cnt_reg;
        stall_cnt_next    = stall_cnt_reg;
        if (flush_run && (redirect_cnt_reg != 16'hFFFF)) begin
            redirect_cnt_next = redirect_cnt_reg + 16'd1;
        end
        if ((state_reg == RUN) && bus.Stall && !bus.PcSel && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            redirect_cnt_reg <= '0;
            stall_cnt_reg    <= '0;
        end else begin
            redirect_cnt_reg <= redirect_cnt_next;
            stall_cnt_reg    <= stall_cnt_next;
        end
    end

    assign bus.RedirectCnt = redirect_cnt_reg;
    assign bus.StallCnt    = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl (PC_W=9).
module tb_fetch_pc_ctrl;
    localparam int PC_W = 9;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cyc;

    fetch_pc_ctrl_if #(.PC_W(PC_W)) bus_if ();

    fetch_pc_ctrl #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus_if.Stall  = 1'b0;
        bus_if.PcSel  = 1'b0;
        bus_if.BrPC   = 32'h0;
        bus_if.Halt   = 1'b0;
        bus_if.Resume = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: rst=%b PC=%03h V=%b F=%b H=%b M=%b", cyc, reset,
                 bus_if.PC, bus_if.PC_Valid, bus_if.Flush, bus_if.Halted, bus_if.Misalign);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'h40;
        step();
        step();
        n_cmp++; if (bus_if.PC !== 9'h000) begin $display("FAIL reset_pc got %h want 000", bus_if.PC); n_err++; end
        n_cmp++; if (bus_if.Halted !== 1'b0) begin $display("FAIL reset_halted got %b want 0", bus_if.Halted); n_err++; end
        n_cmp++; if (bus_if.Misalign !== 1'b0) begin $display("FAIL reset_misalign got %b want 0", bus_if.Misalign); n_err++; end
        n_cmp++; if (bus_if.PC_Valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus_if.PC_Valid); n_err++; end
        n_cmp++; if (bus_if.Flush !== 1'b0) begin $display("FAIL reset_flush got %b want 0", bus_if.Flush); n_err++; end
        clear_inputs();
        reset = 1'b1;
        #1;
        n_cmp++; if (bus_if.PC_Valid !== 1'b1) begin $display("FAIL first_fetch_valid got %b want 1", bus_if.PC_Valid); n_err++; end
        n_cmp++; if (bus_if.PC !== 9'h000) begin $display("FAIL first_fetch_pc got %h want 000", bus_if.PC); n_err++; end
        for (int i = 1; i < 4; i++) begin
            step();
            n_cmp++; if (bus_if.PC !== 9'(4 * i)) begin $display("FAIL seq_pc%0d got %h want %h", i, bus_if.PC, 9'(4 * i)); n_err++; end
            n_cmp++; if (bus_if.Flush !== 1'b0 || bus_if.PC_Valid !== 1'b1) begin $display("FAIL seq_flags%0d got F=%b V=%b want F=0 V=1", i, bus_if.Flush, bus_if.PC_Valid); n_err++; end
        end
    endtask

    task automatic test_redirect_over_stall();
        step();
        n_cmp++; if (bus_if.PC !== 9'h010) begin $display("FAIL pre_redirect_pc got %h want 010", bus_if.PC); n_err++; end
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'h0000_0040;
        bus_if.Stall = 1'b1;
        #1;
        n_cmp++; if (bus_if.Flush !== 1'b1) begin $display("FAIL redirect_flush got %b want 1", bus_if.Flush); n_err++; end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (bus_if.PC !== 9'h040) begin $display("FAIL redirect_pc got %h want 040", bus_if.PC); n_err++; end
        n_cmp++; if (bus_if.Flush !== 1'b0) begin $display("FAIL redirect_flush_drop got %b want 0", bus_if.Flush); n_err++; end
    endtask

    task automatic test_stall();
        bus_if.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus_if.PC !== 9'h040 || bus_if.PC_Valid !== 1'b1) begin $display("FAIL stall_hold%0d got PC=%h V=%b want PC=040 V=1", i, bus_if.PC, bus_if.PC_Valid); n_err++; end
        end
        bus_if.Stall = 1'b0;
        step();
        n_cmp++; if (bus_if.PC !== 9'h044) begin $display("FAIL stall_release got %h want 044", bus_if.PC); n_err++; end
    endtask

    task automatic test_wrap_and_truncate();
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'h0000_01FC;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h1FC) begin $display("FAIL wrap_setup got %h want 1fc", bus_if.PC); n_err++; end
        step();
        n_cmp++; if (bus_if.PC !== 9'h000) begin $display("FAIL wrap_pc got %h want 000", bus_if.PC); n_err++; end
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'hFFFF_FE20;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h020) begin $display("FAIL trunc_pc got %h want 020", bus_if.PC); n_err++; end
        n_cmp++; if (bus_if.Misalign !== 1'b0 || bus_if.Halted !== 1'b0) begin $display("FAIL trunc_flags got M=%b H=%b want M=0 H=0", bus_if.Misalign, bus_if.Halted); n_err++; end
    endtask

    task automatic test_halt();
        bus_if.PcSel = 1'b1;
        bus_if.Halt  = 1'b1;
        bus_if.BrPC  = 32'h0000_0030;
        #1;
        n_cmp++; if (bus_if.Flush !== 1'b1) begin $display("FAIL halt_flush got %b want 1", bus_if.Flush); n_err++; end
        step();
        clear_inputs();
        #1;
        n_cmp++; if (bus_if.Halted !== 1'b1 || bus_if.PC_Valid !== 1'b0) begin $display("FAIL halt_enter got H=%b V=%b want H=1 V=0", bus_if.Halted, bus_if.PC_Valid); n_err++; end
        n_cmp++; if (bus_if.PC !== 9'h030) begin $display("FAIL halt_pc got %h want 030", bus_if.PC); n_err++; end
        for (int i = 0; i < 3; i++) step();
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'h0000_0080;
        bus_if.Stall = 1'b1;
        #1;
        n_cmp++; if (bus_if.Flush !== 1'b0) begin $display("FAIL halted_flush got %b want 0", bus_if.Flush); n_err++; end
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h030 || bus_if.Halted !== 1'b1) begin $display("FAIL halted_ignore got PC=%h H=%b want PC=030 H=1", bus_if.PC, bus_if.Halted); n_err++; end
        bus_if.Resume = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h034 || bus_if.Halted !== 1'b0 || bus_if.PC_Valid !== 1'b1) begin $display("FAIL resume got PC=%h H=%b V=%b want PC=034 H=0 V=1", bus_if.PC, bus_if.Halted, bus_if.PC_Valid); n_err++; end
        bus_if.Resume = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h038 || bus_if.Halted !== 1'b0) begin $display("FAIL resume_in_run got PC=%h H=%b want PC=038 H=0", bus_if.PC, bus_if.Halted); n_err++; end
    endtask

    task automatic test_misalign();
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'h0000_0046;
        #1;
        n_cmp++; if (bus_if.Flush !== 1'b1) begin $display("FAIL misalign_flush got %b want 1", bus_if.Flush); n_err++; end
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h044 || bus_if.Misalign !== 1'b1 || bus_if.Halted !== 1'b1) begin $display("FAIL misalign_enter got PC=%h M=%b H=%b want PC=044 M=1 H=1", bus_if.PC, bus_if.Misalign, bus_if.Halted); n_err++; end
        bus_if.Resume = 1'b1;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.PC !== 9'h048 || bus_if.Misalign !== 1'b1 || bus_if.Halted !== 1'b0) begin $display("FAIL misalign_resume got PC=%h M=%b H=%b want PC=048 M=1 H=0", bus_if.PC, bus_if.Misalign, bus_if.Halted); n_err++; end
        step();
        n_cmp++; if (bus_if.Misalign !== 1'b1) begin $display("FAIL misalign_sticky got %b want 1", bus_if.Misalign); n_err++; end
        reset = 1'b0;
        step();
        n_cmp++; if (bus_if.Misalign !== 1'b0 || bus_if.PC !== 9'h000 || bus_if.PC_Valid !== 1'b0) begin $display("FAIL misalign_reset got M=%b PC=%h V=%b want M=0 PC=000 V=0", bus_if.Misalign, bus_if.PC, bus_if.PC_Valid); n_err++; end
        reset = 1'b1;
    endtask

    task automatic test_reset_while_halted();
        bus_if.PcSel = 1'b1;
        bus_if.Halt  = 1'b1;
        bus_if.BrPC  = 32'h0000_0100;
        step();
        clear_inputs();
        bus_if.Resume = 1'b1;
        reset = 1'b0;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.Halted !== 1'b0 || bus_if.PC !== 9'h000) begin $display("FAIL halt_reset got H=%b PC=%h want H=0 PC=000", bus_if.Halted, bus_if.PC); n_err++; end
        reset = 1'b1;
    endtask

`ifdef FETCH_PC_PERF_CNT_EN
    task automatic test_perf_counters();
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus_if.Stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        clear_inputs();
        bus_if.PcSel = 1'b1;
        bus_if.BrPC  = 32'h10;
        step();
        bus_if.BrPC  = 32'h20;
        step();
        clear_inputs();
        n_cmp++; if (bus_if.StallCnt !== 16'd3) begin $display("FAIL stall_cnt got %0d want 3", bus_if.StallCnt); n_err++; end
        n_cmp++; if (bus_if.RedirectCnt !== 16'd2) begin $display("FAIL redirect_cnt got %0d want 2", bus_if.RedirectCnt); n_err++; end
        bus_if.Stall = 1'b1;
        reset = 1'b0;
        step();
        n_cmp++; if (bus_if.StallCnt !== 16'd0 || bus_if.RedirectCnt !== 16'd0 || bus_if.PC !== 9'h000) begin $display("FAIL cnt_reset got S=%0d R=%0d PC=%h want 0 0 000", bus_if.StallCnt, bus_if.RedirectCnt, bus_if.PC); n_err++; end
        clear_inputs();
        reset = 1'b1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_redirect_over_stall();
        test_stall();
        test_wrap_and_truncate();
        test_halt();
        test_misalign();
        test_reset_while_halted();
`ifdef FETCH_PC_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
